// File: rtl/comp_pkg.sv
// Shared types and the width-generic compare helper for the streaming comparator.
//   cmp_res_e   : encoded three-way compare result
//   cmp_flags_t : one-hot LT/EQ/GT payload held in the result register
//   comp_fn#(W) : static compare(a, b, is_signed) sized by W
package comp_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // Decode a compare result into the one-hot flag payload.
  function automatic cmp_flags_t res_to_flags(input cmp_res_e res);
    cmp_flags_t f;
    f = '0;
    case (res)
      CMP_LT:  f.lt = 1'b1;
      CMP_EQ:  f.eq = 1'b1;
      CMP_GT:  f.gt = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  // Width-parametrised compare. Inverting both MSBs maps two's-complement
  // ordering onto unsigned ordering, so one unsigned comparator serves both modes.
  virtual class comp_fn #(parameter int unsigned W = 8);
    static function cmp_res_e compare(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic         is_signed);
      logic [W-1:0] ka;
      logic [W-1:0] kb;
      ka = a;
      kb = b;
      if (is_signed) begin
        ka[W-1] = ~a[W-1];
        kb[W-1] = ~b[W-1];
      end
      if (ka < kb) begin
        return CMP_LT;
      end else if (ka == kb) begin
        return CMP_EQ;
      end
      return CMP_GT;
    endfunction
  endclass

endpackage

// File: rtl/comp_if.sv
// Signal bundle for the streaming comparator.
//   dut_mp : directions as seen by comp_stream_nbit
//   tb_mp  : the inverse, for a driver/monitor (including clk and rst)
interface comp_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_cmp;
  logic             out_valid;
  logic             out_ready;
  logic             LT;
  logic             EQ;
  logic             GT;
  logic [CNT_W-1:0] cnt_lt;
  logic [CNT_W-1:0] cnt_eq;
  logic [CNT_W-1:0] cnt_gt;
  logic             clr_cnt;
  logic             gt_alarm;

  modport dut_mp (
    input  clk, rst, in_valid, A, B, signed_cmp, out_ready, clr_cnt,
    output in_ready, out_valid, LT, EQ, GT, cnt_lt, cnt_eq, cnt_gt, gt_alarm
  );

  modport tb_mp (
    output clk, rst, in_valid, A, B, signed_cmp, out_ready, clr_cnt,
    input  in_ready, out_valid, LT, EQ, GT, cnt_lt, cnt_eq, cnt_gt, gt_alarm
  );

endinterface

// File: rtl/comp_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
//   clk, rst : clock, async active-high reset
//   inc      : count one event this cycle
//   clr      : synchronous clear, dominates inc
//   q        : current count
module comp_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/comp_stream_nbit.sv
// Streaming WIDTH-bit LT/EQ/GT comparator with a one-deep registered result,
// saturating per-result event counters and a sticky GT-run alarm.
//   in_valid/in_ready, A, B, signed_cmp : operand side (in_ready is combinational)
//   out_valid/out_ready, LT, EQ, GT     : registered result side
//   cnt_lt/cnt_eq/cnt_gt, clr_cnt       : counters of accepted results, sync clear
//   gt_alarm                            : set once RUN_LIMIT consecutive GT accepts occur
module comp_stream_nbit
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RUN_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_cmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             LT,
  output logic             EQ,
  output logic             GT,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  input  logic             clr_cnt,
  output logic             gt_alarm
);

  localparam int unsigned      RUN_W   = $clog2(RUN_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LIMIT);

  logic             r_out_valid;
  cmp_flags_t       r_flags;
  logic [RUN_W-1:0] r_run;
  logic             r_alarm;

  logic             w_accept;
  cmp_res_e         w_res;
  cmp_flags_t       w_flags;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_inc_lt;
  logic             w_inc_eq;
  logic             w_inc_gt;

  // The result slot frees up in the same cycle the consumer takes it.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_res   = comp_fn#(WIDTH)::compare(A, B, signed_cmp);
  assign w_flags = res_to_flags(w_res);

  // Result register: load on accept, otherwise clear flags when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_flags     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_flags     <= w_flags;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_flags     <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign LT        = r_flags.lt;
  assign EQ        = r_flags.eq;
  assign GT        = r_flags.gt;

  // A coincident clear wins, so the accept is not counted.
  assign w_inc_lt = w_accept && !clr_cnt && (w_res == CMP_LT);
  assign w_inc_eq = w_accept && !clr_cnt && (w_res == CMP_EQ);
  assign w_inc_gt = w_accept && !clr_cnt && (w_res == CMP_GT);

  comp_sat_counter #(.CNT_W(CNT_W)) u_cnt_lt (
    .clk (clk),
    .rst (rst),
    .inc (w_inc_lt),
    .clr (clr_cnt),
    .q   (cnt_lt)
  );

  comp_sat_counter #(.CNT_W(CNT_W)) u_cnt_eq (
    .clk (clk),
    .rst (rst),
    .inc (w_inc_eq),
    .clr (clr_cnt),
    .q   (cnt_eq)
  );

  comp_sat_counter #(.CNT_W(CNT_W)) u_cnt_gt (
    .clk (clk),
    .rst (rst),
    .inc (w_inc_gt),
    .clr (clr_cnt),
    .q   (cnt_gt)
  );

  // Next GT-run length: GT extends (saturating), LT/EQ break the run.
  always_comb begin
    w_run_nxt = r_run;
    if (w_accept) begin
      if (w_res == CMP_GT) begin
        if (r_run != RUN_MAX) begin
          w_run_nxt = r_run + RUN_W'(1);
        end
      end else begin
        w_run_nxt = '0;
      end
    end
  end

  // Run length and sticky alarm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= '0;
      r_alarm <= 1'b0;
    end else if (clr_cnt) begin
      r_run   <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_run <= w_run_nxt;
      if (w_run_nxt == RUN_MAX) begin
        r_alarm <= 1'b1;
      end
    end
  end

  assign gt_alarm = r_alarm;

endmodule
